// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the single core data bus between the fetch-side
// page-table walker (freq/fresp) and the memory stage (mreq/mresp).
// Once a requester is granted, the bus stays locked to it until data_ok.
// Only that owner sees the response, and a starvation counter makes sure
// memory eventually wins over a continuously requesting fetch side.
//
// Ports:
//   clk, reset    core clock, asynchronous active-high reset
//   freq / fresp  fetch/PTW request in, response out (0 unless fetch owns)
//   mreq / mresp  memory-stage request in, response out (0 unless memory owns)
//   flush         discard any in-flight response (the bus cycle still completes)
//   dreq / dresp  request to / response from the data bus
//   gnt_f, gnt_m  current owner, one-hot or both 0
//   busy          a transaction is in flight
`timescale 1ns/1ps

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  freq,
  output dbus_resp_t fresp,
  input  dbus_req_t  mreq,
  output dbus_resp_t mresp,
  input  logic       flush,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output logic       gnt_f,
  output logic       gnt_m,
  output logic       busy
);

  localparam int CW = $clog2(MAX_STARVE + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_STARVE);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t          state;
  dbus_req_t       req_q;
  logic            owner_q;      // 0 = fetch, 1 = memory
  logic [CW-1:0]   starve_cnt;

  logic            sel_m;        // memory wins the IDLE arbitration
  logic            win_valid;
  dbus_req_t       win_req;
  logic            owner_valid;  // live valid of the latched owner
  logic            discard;      // response must not reach the owner

  always_comb begin
    sel_m       = mreq.valid && (!freq.valid || (starve_cnt == STARVE_MAX));
    win_valid   = freq.valid || mreq.valid;
    win_req     = sel_m ? mreq : freq;
    owner_valid = owner_q ? mreq.valid : freq.valid;
    discard     = flush || !owner_valid;
  end

  // Outputs. In IDLE the winner goes straight to the bus so that grant-to-issue
  // latency is zero. Reset also gates the outputs directly: a requester still
  // holding valid during reset must not reach the bus through the IDLE path.
  always_comb begin
    dreq  = '0;
    fresp = '0;
    mresp = '0;
    gnt_f = 1'b0;
    gnt_m = 1'b0;
    busy  = 1'b0;
    if (!reset) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (win_valid) begin
            dreq  = win_req;
            gnt_f = !sel_m;
            gnt_m = sel_m;
            // single-cycle bus: the response can arrive in the grant cycle
            if (sel_m) mresp = dresp;
            else       fresp = dresp;
          end
        end
        BUSY: begin
          dreq  = req_q;
          gnt_f = !owner_q;
          gnt_m = owner_q;
          if (!discard) begin
            if (owner_q) mresp = dresp;
            else         fresp = dresp;
          end
        end
        DRAIN: begin
          // bus still locked to the old request, but nobody owns the response
          dreq = req_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= '0;
      owner_q    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            req_q   <= win_req;
            owner_q <= sel_m;
            // data_ok in the grant cycle: latch and completion coincide
            state   <= dresp.data_ok ? IDLE : BUSY;
          end
          if (!mreq.valid || (win_valid && sel_m))
            starve_cnt <= '0;
          else if (win_valid && (starve_cnt != STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
        end
        BUSY: begin
          // flush beats a coinciding data_ok only for routing; the bus cycle
          // is finished either way, so go straight back to IDLE
          if (dresp.data_ok) state <= IDLE;
          else if (discard)  state <= DRAIN;
        end
        DRAIN: begin
          if (dresp.data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
`timescale 1ns/1ps

module tb_dbus_arbiter;
  import dbus_pkg::*;

  logic       clk;
  logic       reset;
  dbus_req_t  freq, mreq, dreq;
  dbus_resp_t fresp, mresp, dresp;
  logic       flush, gnt_f, gnt_m, busy;

  int total = 0;
  int bad   = 0;

  dbus_arbiter #(.MAX_STARVE(4)) dut (
    .clk(clk), .reset(reset),
    .freq(freq), .fresp(fresp),
    .mreq(mreq), .mresp(mresp),
    .flush(flush),
    .dreq(dreq), .dresp(dresp),
    .gnt_f(gnt_f), .gnt_m(gnt_m), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    freq  = '0;
    mreq  = '0;
    dresp = '0;
    flush = 1'b0;
  endtask

  // inputs change 1ns after the rising edge; outputs are sampled at the falling edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b1;
    @(negedge clk);
    total++; if (dreq !== '0)  begin bad++; $display("FAIL reset_dreq: got %h want 0", dreq); end
    total++; if (fresp !== '0 || mresp !== '0) begin bad++; $display("FAIL reset_resp: got f=%h m=%h want 0", fresp, mresp); end
    total++; if ({gnt_f, gnt_m, busy} !== 3'b000) begin bad++; $display("FAIL reset_ctl: got %b want 000", {gnt_f, gnt_m, busy}); end
    freq.valid = 1'b1; freq.addr = 32'h1234_0000;
    #1;
    total++; if (dreq.valid !== 1'b0 || gnt_f !== 1'b0) begin bad++; $display("FAIL reset_live_req: got valid=%b gnt_f=%b want 0 0", dreq.valid, gnt_f); end
    clr();
    cyc();
    reset = 1'b0;
    cyc();
    $display("test_reset done");
  endtask

  task automatic test_fetch_alone();
    int nd = 0;
    int nbusy = 0;
    freq.valid = 1'b1; freq.addr = 32'h8000_1000; freq.size = 3'd2;
    for (int c = 0; c < 5; c++) begin
      dresp = '0;
      if (c == 3) begin dresp.data_ok = 1'b1; dresp.data = 64'hDEAD; end
      if (c == 4) freq = '0;
      @(negedge clk);
      if (fresp.data === 64'hDEAD) nd++;
      if (busy === 1'b1) nbusy++;
      total++; if (mresp !== '0) begin bad++; $display("FAIL fetch_mresp_c%0d: got %h want 0", c, mresp); end
      if (c == 0) begin
        total++; if (gnt_f !== 1'b1 || gnt_m !== 1'b0) begin bad++; $display("FAIL fetch_gnt: got f=%b m=%b want 1 0", gnt_f, gnt_m); end
        total++; if (dreq.valid !== 1'b1 || dreq.addr !== 32'h8000_1000) begin bad++; $display("FAIL fetch_issue: got v=%b a=%h want 1 80001000", dreq.valid, dreq.addr); end
      end
      if (c == 3) begin
        total++; if (fresp.data_ok !== 1'b1) begin bad++; $display("FAIL fetch_data_ok: got %b want 1", fresp.data_ok); end
      end
      cyc();
    end
    total++; if (nd != 1) begin bad++; $display("FAIL fetch_data_cycles: got %0d want 1", nd); end
    total++; if (nbusy != 3) begin bad++; $display("FAIL fetch_busy_cycles: got %0d want 3", nbusy); end
    clr();
    $display("test_fetch_alone done");
  endtask

  task automatic test_owner_switch();
    freq.valid = 1'b1; freq.addr = 32'h1000_0040;
    @(negedge clk);
    total++; if (gnt_f !== 1'b1) begin bad++; $display("FAIL switch_gnt: got %b want 1", gnt_f); end
    cyc();
    freq.addr = 32'h2000_0080;
    @(negedge clk);
    total++; if (dreq.addr !== 32'h1000_0040) begin bad++; $display("FAIL switch_hold1: got %h want 10000040", dreq.addr); end
    cyc();
    dresp.data_ok = 1'b1; dresp.data = 64'h77;
    @(negedge clk);
    total++; if (dreq.addr !== 32'h1000_0040) begin bad++; $display("FAIL switch_hold2: got %h want 10000040", dreq.addr); end
    total++; if (fresp.data_ok !== 1'b1 || fresp.data !== 64'h77) begin bad++; $display("FAIL switch_resp: got ok=%b d=%h want 1 77", fresp.data_ok, fresp.data); end
    cyc();
    clr();
    @(negedge clk);
    total++; if (busy !== 1'b0 || dreq.valid !== 1'b0) begin bad++; $display("FAIL switch_end: got busy=%b v=%b want 0 0", busy, dreq.valid); end
    cyc();
    $display("test_owner_switch done");
  endtask

  task automatic test_starve();
    logic [5:0] exp_m;
    logic [2:0] exp_cnt [6];
    exp_m = 6'b010000;   // bit i: memory wins transaction i
    exp_cnt = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    freq.addr = 32'h0000_0100;
    mreq.addr = 32'h0000_0200;
    for (int i = 0; i < 6; i++) begin
      freq.valid = 1'b1;
      mreq.valid = (i < 5);
      dresp = '0;
      @(negedge clk);
      total++; if (dut.starve_cnt !== exp_cnt[i]) begin bad++; $display("FAIL starve_cnt_%0d: got %0d want %0d", i, dut.starve_cnt, exp_cnt[i]); end
      total++; if (gnt_m !== exp_m[i] || gnt_f !== !exp_m[i]) begin bad++; $display("FAIL starve_gnt_%0d: got f=%b m=%b want m=%b", i, gnt_f, gnt_m, exp_m[i]); end
      cyc();
      dresp.data_ok = 1'b1; dresp.data = 64'(i);
      @(negedge clk);
      total++; if (mresp.data_ok !== exp_m[i] || fresp.data_ok !== !exp_m[i]) begin bad++; $display("FAIL starve_resp_%0d: got f=%b m=%b want m=%b", i, fresp.data_ok, mresp.data_ok, exp_m[i]); end
      $display("starve txn %0d: gnt_f=%b gnt_m=%b", i, !exp_m[i], exp_m[i]);
      cyc();
    end
    clr();
    @(negedge clk);
    total++; if (dut.starve_cnt !== 3'd0) begin bad++; $display("FAIL starve_final: got %0d want 0", dut.starve_cnt); end
    cyc();
  endtask

  task automatic test_flush();
    mreq.valid = 1'b1; mreq.addr = 32'h0000_3000;
    @(negedge clk);
    total++; if (gnt_m !== 1'b1) begin bad++; $display("FAIL flush_gnt: got %b want 1", gnt_m); end
    cyc();
    flush = 1'b1;
    @(negedge clk);
    total++; if (mresp !== '0 || busy !== 1'b1) begin bad++; $display("FAIL flush_pulse: got m=%h busy=%b want 0 1", mresp, busy); end
    cyc();
    flush = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1 || dreq.valid !== 1'b1 || dreq.addr !== 32'h0000_3000) begin bad++; $display("FAIL flush_drain: got busy=%b v=%b a=%h want 1 1 3000", busy, dreq.valid, dreq.addr); end
    cyc();
    dresp.data_ok = 1'b1; dresp.data = 64'h55;
    @(negedge clk);
    total++; if (mresp.data_ok !== 1'b0 || fresp.data_ok !== 1'b0) begin bad++; $display("FAIL flush_discard: got m=%b f=%b want 0 0", mresp.data_ok, fresp.data_ok); end
    cyc();
    dresp = '0; mreq.addr = 32'h0000_3008;
    @(negedge clk);
    total++; if (gnt_m !== 1'b1 || busy !== 1'b0 || dreq.addr !== 32'h0000_3008) begin bad++; $display("FAIL flush_regrant: got g=%b busy=%b a=%h want 1 0 3008", gnt_m, busy, dreq.addr); end
    cyc();
    dresp.data_ok = 1'b1;
    @(negedge clk);
    total++; if (mresp.data_ok !== 1'b1) begin bad++; $display("FAIL flush_next_ok: got %b want 1", mresp.data_ok); end
    cyc();
    clr();
    // flush in IDLE does not block the grant; flush with data_ok in BUSY discards
    freq.valid = 1'b1; freq.addr = 32'h0000_4000; flush = 1'b1;
    @(negedge clk);
    total++; if (gnt_f !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL flush_idle: got g=%b busy=%b want 1 0", gnt_f, busy); end
    cyc();
    dresp.data_ok = 1'b1;
    @(negedge clk);
    total++; if (fresp.data_ok !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL flush_with_ok: got ok=%b busy=%b want 0 1", fresp.data_ok, busy); end
    cyc();
    clr();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_with_ok_idle: got %b want 0", busy); end
    cyc();
    $display("test_flush done");
  endtask

  task automatic test_reset_midflight();
    freq.valid = 1'b1; freq.addr = 32'h0000_5000;
    cyc();
    #1 reset = 1'b1;
    #1;
    total++; if (dreq.valid !== 1'b0 || gnt_f !== 1'b0 || gnt_m !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid: got v=%b f=%b m=%b busy=%b want 0", dreq.valid, gnt_f, gnt_m, busy); end
    dresp.data_ok = 1'b1;
    #1;
    total++; if (fresp.data_ok !== 1'b0) begin bad++; $display("FAIL rst_mid_resp: got %b want 0", fresp.data_ok); end
    freq = '0;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    total++; if (fresp !== '0 || mresp !== '0 || busy !== 1'b0) begin bad++; $display("FAIL rst_late_ok: got f=%h m=%h busy=%b want 0", fresp, mresp, busy); end
    cyc();
    clr();
    $display("test_reset_midflight done");
  endtask

  task automatic test_single_cycle();
    for (int k = 0; k < 4; k++) begin
      logic is_m;
      is_m = k[0];
      if (is_m) begin mreq.valid = 1'b1; mreq.addr = 32'h0000_6000 + 32'(k); end
      else      begin freq.valid = 1'b1; freq.addr = 32'h0000_7000 + 32'(k); end
      dresp.data_ok = 1'b1; dresp.data = 64'h100 + 64'(k);
      @(negedge clk);
      total++; if (gnt_m !== is_m || gnt_f !== !is_m || busy !== 1'b0) begin bad++; $display("FAIL single_gnt_%0d: got f=%b m=%b busy=%b", k, gnt_f, gnt_m, busy); end
      if (is_m) begin
        total++; if (mresp.data_ok !== 1'b1 || mresp.data !== 64'h100 + 64'(k) || fresp !== '0) begin bad++; $display("FAIL single_resp_%0d: got m=%h f=%h", k, mresp, fresp); end
      end else begin
        total++; if (fresp.data_ok !== 1'b1 || fresp.data !== 64'h100 + 64'(k) || mresp !== '0) begin bad++; $display("FAIL single_resp_%0d: got f=%h m=%h", k, fresp, mresp); end
      end
      $display("single txn %0d owner=%s", k, is_m ? "mem" : "fetch");
      cyc();
      clr();
      @(negedge clk);
      total++; if (dreq.valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_bubble_%0d: got v=%b busy=%b want 0 0", k, dreq.valid, busy); end
      cyc();
    end
  endtask

  initial begin
    clr();
    reset = 1'b1;
    cyc();
    test_reset();
    test_fetch_alone();
    test_owner_switch();
    test_starve();
    test_flush();
    test_reset_midflight();
    test_single_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
